// File: rtl/irq_controller.sv
// irq_controller: N-channel interrupt controller with input synchronisation,
// per-channel edge/level mode, masking and a request/ack/eoi handshake that
// holds a stable vector.
// Optional build macro IRQ_NMI_EN: channel CHANNELS-1 becomes non-maskable.
module irq_controller #(
    parameter int unsigned CHANNELS    = 8,
    parameter int unsigned SYNC_STAGES = 2,
    localparam int unsigned VW         = $clog2(CHANNELS)
) (
    input  logic                clock,
    input  logic                reset_n,
    input  logic [CHANNELS-1:0] irq_in,
    input  logic [CHANNELS-1:0] edge_mode,
    input  logic                mask_wr,
    input  logic [CHANNELS-1:0] mask_d,
    output logic [CHANNELS-1:0] mask_q,
    input  logic                pend_set,
    input  logic                pend_clr,
    input  logic [CHANNELS-1:0] pend_d,
    output logic [CHANNELS-1:0] pending_q,
    output logic                irq_out,
    output logic [VW-1:0]       vector,
    input  logic                ack,
    input  logic                eoi,
    output logic                in_service
);

`ifdef IRQ_NMI_EN
    localparam logic [CHANNELS-1:0] NMI_SEL = {1'b1, {(CHANNELS-1){1'b0}}};
`else
    localparam logic [CHANNELS-1:0] NMI_SEL = '0;
`endif

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_SERVICE
    } state_t;

    state_t                               state_q, state_d;
    logic [SYNC_STAGES-1:0][CHANNELS-1:0] sync_q, sync_d;
    logic [CHANNELS-1:0]                  history_q, history_d;
    logic [CHANNELS-1:0]                  pending_d;
    logic [CHANNELS-1:0]                  mask_d_int;
    logic [VW-1:0]                        vector_q, vector_d;

    logic [CHANNELS-1:0] synced;
    logic [CHANNELS-1:0] hw_edge;
    logic [CHANNELS-1:0] active;
    logic [CHANNELS-1:0] clr_sel;
    logic [CHANNELS-1:0] set_sel;
    logic [CHANNELS-1:0] edge_next;
    logic [VW-1:0]       prio_vec;
    logic                ack_take;

    assign synced  = sync_q[SYNC_STAGES-1];
    assign hw_edge = synced & ~history_q;
    // The non-maskable channel ignores its mask bit; mask_q still reads back as written.
    assign active  = pending_q & (mask_q | NMI_SEL);

    // Synchroniser shift chain and edge history register inputs.
    always_comb begin
        sync_d    = '0;
        sync_d[0] = irq_in;
        for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
            sync_d[i] = sync_q[i-1];
        end
        history_d = synced;
    end

    // Highest active index wins.
    always_comb begin
        prio_vec = '0;
        for (int unsigned i = 0; i < CHANNELS; i++) begin
            if (active[i]) begin
                prio_vec = VW'(i);
            end
        end
    end

    // Pending update: the ack-clear is folded into the clear select, so a set strobe
    // or a coincident hardware edge overrides both kinds of clear.
    always_comb begin
        ack_take = (state_q == ST_REQ) && active[vector_q] && ack;
        clr_sel  = pend_clr ? pend_d : '0;
        if (ack_take) begin
            clr_sel[vector_q] = 1'b1;
        end
        set_sel   = pend_set ? pend_d : '0;
        edge_next = (pending_q & ~clr_sel) | set_sel | hw_edge;
        pending_d = (edge_mode & edge_next) | (~edge_mode & synced);
    end

    // Mask register load.
    always_comb begin
        mask_d_int = mask_wr ? mask_d : mask_q;
    end

    // Request/acknowledge/end-of-interrupt sequencing with frozen vector.
    always_comb begin
        state_d  = state_q;
        vector_d = vector_q;
        case (state_q)
            ST_IDLE: begin
                if (|active) begin
                    vector_d = prio_vec;
                    state_d  = ST_REQ;
                end
            end
            ST_REQ: begin
                if (!active[vector_q]) begin
                    state_d = ST_IDLE;
                end else if (ack) begin
                    state_d = ST_SERVICE;
                end
            end
            ST_SERVICE: begin
                if (eoi) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= ST_IDLE;
            sync_q    <= '0;
            history_q <= '0;
            pending_q <= '0;
            mask_q    <= '0;
            vector_q  <= '0;
        end else begin
            state_q   <= state_d;
            sync_q    <= sync_d;
            history_q <= history_d;
            pending_q <= pending_d;
            mask_q    <= mask_d_int;
            vector_q  <= vector_d;
        end
    end

    assign irq_out    = (state_q == ST_REQ);
    assign in_service = (state_q == ST_SERVICE);
    assign vector     = vector_q;

endmodule

// File: tb/tb_irq_controller.sv
// tb_irq_controller: directed and randomized stimulus for irq_controller, checked
// cycle by cycle against a behavioural model through a scoreboard queue.
// Honours IRQ_NMI_EN in the same way as the design.
module tb_irq_controller;

    localparam int CH   = 8;
    localparam int SYNC = 2;

`ifdef IRQ_NMI_EN
    localparam bit [CH-1:0] NMI    = 8'h80;
    localparam bit          NMI_ON = 1'b1;
`else
    localparam bit [CH-1:0] NMI    = 8'h00;
    localparam bit          NMI_ON = 1'b0;
`endif

    logic          clock = 1'b0;
    logic          reset_n;
    logic [CH-1:0] irq_in, edge_mode, mask_d, mask_q, pend_d, pending_q;
    logic          mask_wr, pend_set, pend_clr, irq_out, ack, eoi, in_service;
    logic [2:0]    vector;

    int checks = 0;
    int errors = 0;

    typedef struct {
        bit [CH-1:0] pend;
        bit [CH-1:0] mask;
        bit          irq;
        int          vec;
        bit          svc;
    } exp_t;

    exp_t sb[$];

    irq_controller #(.CHANNELS(CH), .SYNC_STAGES(SYNC)) dut (
        .clock(clock), .reset_n(reset_n), .irq_in(irq_in), .edge_mode(edge_mode),
        .mask_wr(mask_wr), .mask_d(mask_d), .mask_q(mask_q),
        .pend_set(pend_set), .pend_clr(pend_clr), .pend_d(pend_d), .pending_q(pending_q),
        .irq_out(irq_out), .vector(vector), .ack(ack), .eoi(eoi), .in_service(in_service)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int highest(input bit [CH-1:0] v);
        for (int i = CH - 1; i >= 0; i--) begin
            if (v[i]) return i;
        end
        return 0;
    endfunction

    // Reference model: delay line of input snapshots, pending set as a bit vector,
    // handshake as "requesting"/"serving" flags.
    bit [CH-1:0] m_dl[SYNC];
    bit [CH-1:0] m_hist, m_pend, m_mask;
    bit          m_req, m_svc;
    int          m_vec;

    initial begin
        forever begin
            @(posedge clock or negedge reset_n);
            if (!reset_n) begin
                for (int i = 0; i < SYNC; i++) m_dl[i] = '0;
                m_hist = '0; m_pend = '0; m_mask = '0;
                m_req = 0; m_svc = 0; m_vec = 0;
                sb.delete();
            end else begin
                bit [CH-1:0] synced, rise, act, np;
                bit          ackclr, nreq, nsvc;
                int          nvec;
                exp_t        e;
                synced = m_dl[SYNC-1];
                rise   = synced & ~m_hist;
                act    = m_pend & (m_mask | NMI);
                ackclr = 0; nreq = m_req; nsvc = m_svc; nvec = m_vec;
                if (m_svc) begin
                    if (eoi) nsvc = 0;
                end else if (m_req) begin
                    if (!act[m_vec]) nreq = 0;
                    else if (ack) begin nreq = 0; nsvc = 1; ackclr = 1; end
                end else if (act != 0) begin
                    nreq = 1; nvec = highest(act);
                end
                for (int c = 0; c < CH; c++) begin
                    if (edge_mode[c]) begin
                        bit b;
                        b = m_pend[c];
                        if (pend_clr && pend_d[c]) b = 0;
                        if (ackclr && c == m_vec) b = 0;
                        if (pend_set && pend_d[c]) b = 1;
                        if (rise[c]) b = 1;
                        np[c] = b;
                    end else begin
                        np[c] = synced[c];
                    end
                end
                if (mask_wr) m_mask = mask_d;
                m_pend = np; m_req = nreq; m_svc = nsvc; m_vec = nvec;
                m_hist = synced;
                for (int i = SYNC - 1; i > 0; i--) m_dl[i] = m_dl[i-1];
                m_dl[0] = irq_in;
                e.pend = m_pend; e.mask = m_mask; e.irq = m_req; e.vec = m_vec; e.svc = m_svc;
                sb.push_back(e);
            end
        end
    end

    // Monitor: compares the DUT against the oldest expectation each cycle.
    initial begin
        forever begin
            @(negedge clock);
            if (reset_n && sb.size() > 0) begin
                exp_t e;
                e = sb.pop_front();
                chk("pending_q", int'(pending_q), int'(e.pend));
                chk("mask_q", int'(mask_q), int'(e.mask));
                chk("irq_out", int'(irq_out), int'(e.irq));
                chk("in_service", int'(in_service), int'(e.svc));
                if (e.irq || e.svc) chk("vector", int'(vector), e.vec);
            end
        end
    end

    task automatic step(input int n = 1);
        repeat (n) begin
            @(negedge clock);
            #1;
        end
    endtask

    task automatic clear_strobes();
        mask_wr = 0; pend_set = 0; pend_clr = 0; ack = 0; eoi = 0; pend_d = '0;
    endtask

    // Bring the controller back to IDLE with nothing pending, mask all-ones.
    task automatic settle();
        clear_strobes();
        irq_in = '0; edge_mode = '1;
        step(4);
        pend_clr = 1; pend_d = '1; eoi = 1; mask_wr = 1; mask_d = '1;
        step(1);
        clear_strobes();
        step(2);
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_pending"}, int'(pending_q), 0);
        chk({tag, "_mask"}, int'(mask_q), 0);
        chk({tag, "_irq_out"}, int'(irq_out), 0);
        chk({tag, "_vector"}, int'(vector), 0);
        chk({tag, "_in_service"}, int'(in_service), 0);
    endtask

    initial begin
        reset_n = 0;
        irq_in = '0; edge_mode = '1; mask_d = '0;
        clear_strobes();
        step(3);
        check_reset_values("reset");
        reset_n = 1;
        step(2);

        // Single edge channel: latency and vector.
        settle();
        irq_in[3] = 1;
        step(3);
        chk("t1_pending", int'(pending_q), 8'h08);
        chk("t1_irq_early", int'(irq_out), 0);
        step(1);
        chk("t1_irq", int'(irq_out), 1);
        chk("t1_vector", int'(vector), 3);

        // Two simultaneous edges: highest first, lower after eoi.
        settle();
        irq_in[2] = 1; irq_in[5] = 1;
        step(4);
        chk("t2_vector_hi", int'(vector), 5);
        ack = 1; step(1); ack = 0;
        chk("t2_pending", int'(pending_q), 8'h04);
        chk("t2_in_service", int'(in_service), 1);
        eoi = 1; step(1); eoi = 0;
        step(1);
        chk("t2_vector_lo", int'(vector), 2);
        chk("t2_irq", int'(irq_out), 1);

        // Spurious withdrawal by masking the requested channel.
        settle();
        pend_set = 1; pend_d = 8'h02; step(1); clear_strobes();
        step(1);
        chk("t3_irq", int'(irq_out), 1);
        chk("t3_vector", int'(vector), 1);
        mask_wr = 1; mask_d = 8'hFD; step(1); clear_strobes();
        step(1);
        chk("t3_withdrawn", int'(irq_out), 0);
        chk("t3_pending1", int'(pending_q[1]), 1);

        // Level channel survives ack and follows the line.
        settle();
        edge_mode = 8'hFE; irq_in[0] = 1;
        step(4);
        ack = 1; step(1); ack = 0;
        eoi = 1; step(1); eoi = 0;
        step(1);
        chk("t4_pending0", int'(pending_q[0]), 1);
        chk("t4_irq", int'(irq_out), 1);
        chk("t4_vector", int'(vector), 0);
        ack = 1; step(1); ack = 0;
        irq_in[0] = 0;
        step(3);
        chk("t4_level_drop", int'(pending_q[0]), 0);

        // Clear coinciding with a hardware edge, then a software set.
        settle();
        irq_in[4] = 1;
        step(2);
        pend_clr = 1; pend_d = 8'h10; step(1); clear_strobes();
        chk("t5_edge_wins", int'(pending_q[4]), 1);
        pend_set = 1; pend_d = 8'h40; step(1); clear_strobes();
        chk("t5_sw_set", int'(pending_q[6]), 1);
        chk("t5_irq", int'(irq_out), 1);

        // Top channel with everything masked: only a non-maskable build requests.
        settle();
        mask_wr = 1; mask_d = '0; step(1); clear_strobes();
        irq_in[7] = 1;
        step(5);
        chk("t6_nmi_irq", int'(irq_out), int'(NMI_ON));
        if (NMI_ON) chk("t6_nmi_vector", int'(vector), 7);
        chk("t6_mask_readback", int'(mask_q), 0);

        // Randomized traffic, with a reset asserted partway through.
        settle();
        for (int cyc = 0; cyc < 3000; cyc++) begin
            clear_strobes();
            if ($urandom_range(0, 63) == 0) edge_mode = CH'($urandom);
            if ($urandom_range(0, 3) == 0) irq_in = irq_in ^ CH'(1 << $urandom_range(0, CH - 1));
            ack = ($urandom_range(0, 3) == 0);
            eoi = ($urandom_range(0, 5) == 0);
            if ($urandom_range(0, 15) == 0) begin pend_set = 1; pend_d = CH'($urandom); end
            if ($urandom_range(0, 15) == 0) begin pend_clr = 1; pend_d = CH'($urandom); end
            if ($urandom_range(0, 19) == 0) begin mask_wr = 1; mask_d = CH'($urandom); end
            if (cyc == 1500) begin
                reset_n = 0;
                #1;
                check_reset_values("midreset");
                step(1);
                reset_n = 1;
            end
            step(1);
        end
        clear_strobes();
        step(3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
